axi_sync_buffer_bridge: RTL

Single-clock, fully parametrised AXI4 buffering bridge between a master-side port (M_*) and a bus-side port (B_*). It holds one show-ahead FIFO per channel (AW, W, B, AR, R), each with configurable depth. It limits outstanding write and read bursts and stops W beats from reaching the bus ahead of their AW. It replaces per-channel async bridges wherever master, slave and interconnect share BUS_CLK, while keeping outstanding support and the fifo_empty_flag status.

---
 rtl/axi_sync_buffer_bridge.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_sync_buffer_bridge.sv
// Single-clock AXI4 buffering bridge: one show-ahead FIFO per channel, outstanding-burst
// limiting on AW/AR, and W credit so no write beat reaches the bus ahead of its address.

module axi_sync_buffer_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_rdata
);
    localparam int ABITS = $clog2(DEPTH);
    localparam int PBITS = ABITS + 1;

    logic [PBITS-1:0] r_wptr;
    logic [PBITS-1:0] r_rptr;
    logic             r_full;
    logic             r_empty;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_push;
    logic             w_pop;
    logic [PBITS-1:0] w_wptr_nxt;
    logic [PBITS-1:0] w_rptr_nxt;

    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign w_push     = i_push && !r_full;
    assign w_pop      = i_pop && !r_empty;
    assign w_wptr_nxt = r_wptr + PBITS'(w_push);
    assign w_rptr_nxt = r_rptr + PBITS'(w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_empty <= (w_wptr_nxt == w_rptr_nxt);
            r_full  <= (w_wptr_nxt[ABITS] != w_rptr_nxt[ABITS]) &&
                       (w_wptr_nxt[ABITS-1:0] == w_rptr_nxt[ABITS-1:0]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr[ABITS-1:0]] <= i_wdata;
        end
    end

    assign o_ready = !r_full;
    assign o_empty = r_empty;
    assign o_rdata = r_mem[r_rptr[ABITS-1:0]];
endmodule

module axi_sync_buffer_bridge #(
    parameter int ID_WIDTH        = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_DEPTH      = 4,
    parameter int DATA_DEPTH      = 16,
    parameter int MAX_OUTSTANDING = 4,
    localparam int AXW = ID_WIDTH + ADDR_WIDTH + 10,
    localparam int WW  = DATA_WIDTH + DATA_WIDTH / 8 + 1,
    localparam int BW  = ID_WIDTH + 2,
    localparam int RW  = ID_WIDTH + DATA_WIDTH + 3,
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic           BUS_CLK,
    input  logic           BUS_RSTN,
    input  logic [2:0]     M_REQ_VALID,
    output logic [2:0]     M_REQ_READY,
    input  logic [AXW-1:0] M_AW_PAYLOAD,
    input  logic [WW-1:0]  M_W_PAYLOAD,
    input  logic [AXW-1:0] M_AR_PAYLOAD,
    output logic [1:0]     M_RSP_VALID,
    input  logic [1:0]     M_RSP_READY,
    output logic [BW-1:0]  M_B_PAYLOAD,
    output logic [RW-1:0]  M_R_PAYLOAD,
    output logic [2:0]     B_REQ_VALID,
    input  logic [2:0]     B_REQ_READY,
    output logic [AXW-1:0] B_AW_PAYLOAD,
    output logic [WW-1:0]  B_W_PAYLOAD,
    output logic [AXW-1:0] B_AR_PAYLOAD,
    input  logic [1:0]     B_RSP_VALID,
    output logic [1:0]     B_RSP_READY,
    input  logic [BW-1:0]  B_B_PAYLOAD,
    input  logic [RW-1:0]  B_R_PAYLOAD,
    output logic [4:0]     fifo_empty_flag,
    output logic [CW-1:0]  wr_outstanding,
    output logic [CW-1:0]  rd_outstanding
);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

    logic [CW-1:0] r_wr_os;
    logic [CW-1:0] r_rd_os;
    logic [CW-1:0] r_wcredit;

    logic w_aw_empty;
    logic w_w_empty;
    logic w_b_empty;
    logic w_ar_empty;
    logic w_r_empty;
    logic w_aw_issue;
    logic w_w_issue;
    logic w_ar_issue;
    logic w_aw_fire;
    logic w_w_last_fire;
    logic w_ar_fire;
    logic w_b_fire;
    logic w_r_last_fire;

    // Saturating up/down counter; a decrement at zero is a protocol violation and holds.
    function automatic logic [CW-1:0] f_count(input logic [CW-1:0] cnt,
                                              input logic inc, input logic dec);
        f_count = cnt;
        if (inc && !dec && (cnt < MAX_C)) begin
            f_count = cnt + 1'b1;
        end else if (dec && !inc && (cnt != '0)) begin
            f_count = cnt - 1'b1;
        end
    endfunction

    axi_sync_buffer_bridge_fifo #(.WIDTH(AXW), .DEPTH(ADDR_DEPTH)) u_aw_fifo (
        .i_clk   (BUS_CLK),
        .i_rst_n (BUS_RSTN),
        .i_push  (M_REQ_VALID[0]),
        .o_ready (M_REQ_READY[0]),
        .i_wdata (M_AW_PAYLOAD),
        .i_pop   (w_aw_fire),
        .o_empty (w_aw_empty),
        .o_rdata (B_AW_PAYLOAD)
    );

    axi_sync_buffer_bridge_fifo #(.WIDTH(WW), .DEPTH(DATA_DEPTH)) u_w_fifo (
        .i_clk   (BUS_CLK),
        .i_rst_n (BUS_RSTN),
        .i_push  (M_REQ_VALID[1]),
        .o_ready (M_REQ_READY[1]),
        .i_wdata (M_W_PAYLOAD),
        .i_pop   (w_w_issue && B_REQ_READY[1]),
        .o_empty (w_w_empty),
        .o_rdata (B_W_PAYLOAD)
    );

    axi_sync_buffer_bridge_fifo #(.WIDTH(AXW), .DEPTH(ADDR_DEPTH)) u_ar_fifo (
        .i_clk   (BUS_CLK),
        .i_rst_n (BUS_RSTN),
        .i_push  (M_REQ_VALID[2]),
        .o_ready (M_REQ_READY[2]),
        .i_wdata (M_AR_PAYLOAD),
        .i_pop   (w_ar_fire),
        .o_empty (w_ar_empty),
        .o_rdata (B_AR_PAYLOAD)
    );

    axi_sync_buffer_bridge_fifo #(.WIDTH(BW), .DEPTH(ADDR_DEPTH)) u_b_fifo (
        .i_clk   (BUS_CLK),
        .i_rst_n (BUS_RSTN),
        .i_push  (B_RSP_VALID[0]),
        .o_ready (B_RSP_READY[0]),
        .i_wdata (B_B_PAYLOAD),
        .i_pop   (M_RSP_READY[0]),
        .o_empty (w_b_empty),
        .o_rdata (M_B_PAYLOAD)
    );

    axi_sync_buffer_bridge_fifo #(.WIDTH(RW), .DEPTH(DATA_DEPTH)) u_r_fifo (
        .i_clk   (BUS_CLK),
        .i_rst_n (BUS_RSTN),
        .i_push  (B_RSP_VALID[1]),
        .o_ready (B_RSP_READY[1]),
        .i_wdata (B_R_PAYLOAD),
        .i_pop   (M_RSP_READY[1]),
        .o_empty (w_r_empty),
        .o_rdata (M_R_PAYLOAD)
    );

    // W is released only against registered credit, so a beat trails its AW by a cycle.
    assign w_aw_issue    = !w_aw_empty && (r_wr_os < MAX_C);
    assign w_ar_issue    = !w_ar_empty && (r_rd_os < MAX_C);
    assign w_w_issue     = !w_w_empty && (r_wcredit != '0);
    assign w_aw_fire     = w_aw_issue && B_REQ_READY[0];
    assign w_ar_fire     = w_ar_issue && B_REQ_READY[2];
    assign w_w_last_fire = w_w_issue && B_REQ_READY[1] && B_W_PAYLOAD[0];
    assign w_b_fire      = !w_b_empty && M_RSP_READY[0];
    assign w_r_last_fire = !w_r_empty && M_RSP_READY[1] && M_R_PAYLOAD[0];

    always_ff @(posedge BUS_CLK or negedge BUS_RSTN) begin
        if (!BUS_RSTN) begin
            r_wr_os   <= '0;
            r_rd_os   <= '0;
            r_wcredit <= '0;
        end else begin
            r_wr_os   <= f_count(r_wr_os, w_aw_fire, w_b_fire);
            r_rd_os   <= f_count(r_rd_os, w_ar_fire, w_r_last_fire);
            r_wcredit <= f_count(r_wcredit, w_aw_fire, w_w_last_fire);
        end
    end

    assign B_REQ_VALID     = {w_ar_issue, w_w_issue, w_aw_issue};
    assign M_RSP_VALID     = {!w_r_empty, !w_b_empty};
    assign fifo_empty_flag = {w_r_empty, w_ar_empty, w_b_empty, w_w_empty, w_aw_empty};
    assign wr_outstanding  = r_wr_os;
    assign rd_outstanding  = r_rd_os;
endmodule
